// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the load/store sequencer between the multicycle CPU
// MEM stage and the big-endian, byte-addressed data RAM.
//   - access size codes as carried on the 'size' request field
//   - sequencer state encoding
//   - default RAM depth in bytes
//   - helper that flags alignment and size violations of a request
// ---------------------------------------------------------------------------
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   localparam int DEFAULT_MEM_BYTES = 61;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      MRG_WR,
      WR,
      DONE
   } accessStateT;

   // True when the size code is unusable or the byte offset does not suit it.
   function automatic logic badShape(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_HALF:    bad = offset[0];
         SZ_WORD:    bad = (offset != 2'b00);
         SZ_ILLEGAL: bad = 1'b1;
         default:    bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational big-endian lane steering for one RAM word.
//   word       : word read from RAM
//   offset     : byte offset of the access inside the word (Addr[1:0])
//   size       : SZ_BYTE / SZ_HALF / SZ_WORD
//   signExt    : 1 = sign-extend sub-word loads, 0 = zero-extend
//   wdata      : right-justified store data
//   loadValue  : addressed lane(s) extended to 32 bits
//   mergedWord : read word with the addressed lane(s) replaced by wdata
// Byte lane for offset o is word[31-8o -: 8]; the half lane is [31:16] for
// offset 0 and [15:0] for offset 2.
// ---------------------------------------------------------------------------
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        signExt,
   input  logic [31:0] wdata,
   output logic [31:0] loadValue,
   output logic [31:0] mergedWord
);

   logic [7:0]  byteVal;
   logic [15:0] halfVal;

   // Pick the addressed byte and half out of the word, big-endian order.
   always_comb begin
      byteVal = word[7:0];
      case (offset)
         2'd0:    byteVal = word[31:24];
         2'd1:    byteVal = word[23:16];
         2'd2:    byteVal = word[15:8];
         default: byteVal = word[7:0];
      endcase
      halfVal = offset[1] ? word[15:0] : word[31:16];
   end

   // Extend the selected lane; word loads pass straight through.
   always_comb begin
      loadValue = word;
      case (size)
         SZ_BYTE: loadValue = {{24{signExt & byteVal[7]}}, byteVal};
         SZ_HALF: loadValue = {{16{signExt & halfVal[15]}}, halfVal};
         default: loadValue = word;
      endcase
   end

   // Overwrite only the addressed lane(s); the rest keep the value just read.
   always_comb begin
      mergedWord = word;
      case (size)
         SZ_BYTE: begin
            case (offset)
               2'd0:    mergedWord[31:24] = wdata[7:0];
               2'd1:    mergedWord[23:16] = wdata[7:0];
               2'd2:    mergedWord[15:8]  = wdata[7:0];
               default: mergedWord[7:0]   = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (offset[1])
               mergedWord[15:0] = wdata[15:0];
            else
               mergedWord[31:16] = wdata[15:0];
         end
         default: mergedWord = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store sequencer for the MEM stage. Turns lw/lh/lhu/lb/lbu/sw/sh/sb
// requests into word-aligned RAM reads and writes; sub-word stores are done
// as read-modify-write. All RAM strobes are flops so the RAM sees clean
// levels.
// Ports:
//   CLK, Reset      : clock, synchronous active-high reset
//   req             : start request, only looked at in IDLE
//   wr              : 1 store, 0 load
//   size            : 00 byte, 01 half, 10 word, 11 illegal
//   sign_ext        : sub-word loads: 1 sign-extend, 0 zero-extend
//   Addr, WData     : byte address and right-justified store data
//   busy            : a transaction is in flight
//   done, err       : one-cycle completion pulse, err qualifies it
//   RData           : last successful load result
//   ram_Address     : word-aligned RAM address
//   ram_DataIn      : word written to RAM
//   ram_mRD/ram_mWR : registered RAM read / write enables
//   ram_DataOut     : combinational read word from RAM
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
   parameter int ADDR_W    = 32
)
(
   input  logic              CLK,
   input  logic              Reset,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [31:0]       WData,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       RData,
   output logic [ADDR_W-1:0] ram_Address,
   output logic [31:0]       ram_DataIn,
   output logic              ram_mRD,
   output logic              ram_mWR,
   input  logic [31:0]       ram_DataOut
);

   accessStateT state;
   accessStateT nextState;

   // Request fields captured at acceptance
   logic        wrReg;
   logic [1:0]  sizeReg;
   logic        signExtReg;
   logic [1:0]  offsetReg;
   logic [31:0] wdataReg;

   logic [ADDR_W-1:0] alignedAddr;
   logic [ADDR_W:0]   lastByte;
   logic              outOfRange;
   logic              reqErr;
   logic              accept;
   logic              wordStore;

   logic [31:0] loadValue;
   logic [31:0] mergedWord;

   // Request checks. The last byte of the containing word is computed one
   // bit wider so an address near the top of the space cannot wrap into range.
   always_comb begin
      alignedAddr = {Addr[ADDR_W-1:2], 2'b00};
      lastByte    = {1'b0, alignedAddr} + (ADDR_W+1)'(3);
      outOfRange  = lastByte > (ADDR_W+1)'(MEM_BYTES - 1);
      reqErr      = badShape(size, Addr[1:0]) | outOfRange;
      accept      = (state == IDLE) && req;
      wordStore   = wr && (size == SZ_WORD);
   end

   mem_lane_align uLaneAlign (
      .word       (ram_DataOut),
      .offset     (offsetReg),
      .size       (sizeReg),
      .signExt    (signExtReg),
      .wdata      (wdataReg),
      .loadValue  (loadValue),
      .mergedWord (mergedWord)
   );

   // Next-state logic. Word stores skip the read; everything else that is
   // legal reads first. Errors go straight to DONE without touching the RAM.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (reqErr)
                  nextState = DONE;
               else if (wordStore)
                  nextState = WR;
               else
                  nextState = RD;
            end
         end
         RD:      nextState = wrReg ? MRG_WR : DONE;
         MRG_WR:  nextState = DONE;
         WR:      nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State and output registers. Strobes, busy and done are registered
   // decodes of the next state so they change only on clock edges. The RAM
   // address and write data are loaded on the edge entering the access and
   // then held, so they never move while a write strobe is already high.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         ram_mRD     <= 1'b0;
         ram_mWR     <= 1'b0;
         RData       <= '0;
         ram_Address <= '0;
         ram_DataIn  <= '0;
         wrReg       <= 1'b0;
         sizeReg     <= SZ_BYTE;
         signExtReg  <= 1'b0;
         offsetReg   <= 2'b00;
         wdataReg    <= '0;
      end else begin
         state   <= nextState;
         busy    <= (nextState != IDLE);
         done    <= (nextState == DONE);
         ram_mRD <= (nextState == RD);
         ram_mWR <= (nextState == WR) || (nextState == MRG_WR);

         if (accept) begin
            wrReg      <= wr;
            sizeReg    <= size;
            signExtReg <= sign_ext;
            offsetReg  <= Addr[1:0];
            wdataReg   <= WData;
            err        <= reqErr;
            if (!reqErr) begin
               ram_Address <= alignedAddr;
               if (wordStore)
                  ram_DataIn <= WData;
            end
         end else if (state == DONE) begin
            err <= 1'b0;
         end

         if (state == RD) begin
            if (wrReg)
               ram_DataIn <= mergedWord;
            else
               RData <= loadValue;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit with a small word RAM model. Each
// request pushes its expected completion into a queue; a monitor pops and
// compares whenever done is seen. Strobe timing is checked per request.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   import mem_access_pkg::*;

   logic        CLK;
   logic        Reset;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] Addr;
   logic [31:0] WData;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] RData;
   logic [31:0] ram_Address;
   logic [31:0] ram_DataIn;
   logic        ram_mRD;
   logic        ram_mWR;
   logic [31:0] ram_DataOut;

   typedef struct {
      logic        expErr;
      logic [31:0] expRdata;
   } expectT;

   expectT expQ[$];

   int checks;
   int fails;

   logic [31:0] mem [0:15];
   logic        initMem;

   logic        prevMwr;
   logic        prevReset;
   logic [31:0] prevAddr;
   logic [31:0] prevDataIn;

   mem_access_unit #(.MEM_BYTES(61), .ADDR_W(32)) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .req         (req),
      .wr          (wr),
      .size        (size),
      .sign_ext    (sign_ext),
      .Addr        (Addr),
      .WData       (WData),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .RData       (RData),
      .ram_Address (ram_Address),
      .ram_DataIn  (ram_DataIn),
      .ram_mRD     (ram_mRD),
      .ram_mWR     (ram_mWR),
      .ram_DataOut (ram_DataOut)
   );

   // Free-running clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // RAM model: combinational read, write while the strobe is high
   assign ram_DataOut = mem[ram_Address[5:2]];

   always @(posedge CLK) begin
      if (initMem) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0] <= 32'hCAFE0123;
         mem[2] <= 32'h11223344;
         mem[3] <= 32'h80FF7F01;
      end else if (ram_mWR) begin
         mem[ram_Address[5:2]] <= ram_DataIn;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Remember pre-edge RAM interface values for the stability check
   always @(posedge CLK) begin
      prevMwr    <= ram_mWR;
      prevReset  <= Reset;
      prevAddr   <= ram_Address;
      prevDataIn <= ram_DataIn;
   end

   // Interface rules: read and write never together; address and data
   // held across an edge that ends a write cycle.
   always @(negedge CLK) begin
      if (ram_mRD || ram_mWR)
         checkOutput("strobeExclusive", {31'b0, ram_mRD & ram_mWR}, 32'h0);
      if (prevMwr && !prevReset) begin
         checkOutput("addrHeldAfterWrite", ram_Address, prevAddr);
         checkOutput("dataHeldAfterWrite", ram_DataIn, prevDataIn);
      end
   end

   // Scoreboard monitor
   always @(negedge CLK) begin
      expectT e;
      if (done) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 32'h1, 32'h0);
         end else begin
            e = expQ.pop_front();
            checkOutput("err", {31'b0, err}, {31'b0, e.expErr});
            checkOutput("rdata", RData, e.expRdata);
         end
      end
   end

   // One request: drive, watch strobes/done for six cycles, compare timing.
   task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic se,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic expErr, input logic [31:0] expRdata,
                                input logic [7:0] expMrd, input logic [7:0] expMwr,
                                input logic [7:0] expDone, input logic [31:0] expDataIn);
      logic [7:0] mrdMask;
      logic [7:0] mwrMask;
      logic [7:0] doneMask;
      mrdMask  = '0;
      mwrMask  = '0;
      doneMask = '0;
      expQ.push_back('{expErr: expErr, expRdata: expRdata});
      @(negedge CLK);
      wr = w; size = sz; sign_ext = se; Addr = a; WData = wd; req = 1'b1;
      @(posedge CLK);
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         if (k == 1) begin
            req = 1'b0;
            Addr = ~a;
            WData = ~wd;
            size = ~sz;
            wr = ~w;
            sign_ext = ~se;
         end
         mrdMask[k]  = ram_mRD;
         mwrMask[k]  = ram_mWR;
         doneMask[k] = done;
         if (ram_mRD || ram_mWR)
            checkOutput("ramAddress", ram_Address, a & 32'hFFFF_FFFC);
         if (ram_mWR)
            checkOutput("ramDataIn", ram_DataIn, expDataIn);
      end
      checkOutput("mrdCycles", {24'b0, mrdMask}, {24'b0, expMrd});
      checkOutput("mwrCycles", {24'b0, mwrMask}, {24'b0, expMwr});
      checkOutput("doneCycles", {24'b0, doneMask}, {24'b0, expDone});
   endtask

   task automatic checkResetOutputs();
      checkOutput("rstBusy", {31'b0, busy}, 32'h0);
      checkOutput("rstDone", {31'b0, done}, 32'h0);
      checkOutput("rstErr", {31'b0, err}, 32'h0);
      checkOutput("rstMrd", {31'b0, ram_mRD}, 32'h0);
      checkOutput("rstMwr", {31'b0, ram_mWR}, 32'h0);
      checkOutput("rstRData", RData, 32'h0);
      checkOutput("rstAddress", ram_Address, 32'h0);
      checkOutput("rstDataIn", ram_DataIn, 32'h0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int mrdCount;
      int doneCount;
      logic doneSeenBefore;
      logic [7:0] mwrSeen;

      checks = 0;
      fails  = 0;
      Reset = 1'b1; initMem = 1'b1;
      req = 1'b0; wr = 1'b0; size = SZ_WORD; sign_ext = 1'b0;
      Addr = '0; WData = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checkResetOutputs();
      Reset = 1'b0; initMem = 1'b0;

      // Loads
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd8,  32'h0, 1'b0, 32'h11223344, 8'h02, 8'h00, 8'h04, 32'h0);
      applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'd13, 32'h0, 1'b0, 32'hFFFFFFFF, 8'h02, 8'h00, 8'h04, 32'h0);
      applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'd12, 32'h0, 1'b0, 32'h00000080, 8'h02, 8'h00, 8'h04, 32'h0);
      applyStimulus(1'b0, SZ_HALF, 1'b1, 32'd14, 32'h0, 1'b0, 32'h00007F01, 8'h02, 8'h00, 8'h04, 32'h0);
      applyStimulus(1'b0, SZ_HALF, 1'b1, 32'd12, 32'h0, 1'b0, 32'hFFFF80FF, 8'h02, 8'h00, 8'h04, 32'h0);
      applyStimulus(1'b0, SZ_HALF, 1'b0, 32'd12, 32'h0, 1'b0, 32'h000080FF, 8'h02, 8'h00, 8'h04, 32'h0);

      // Sub-word stores (read-modify-write), RData must stay put
      applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'd10, 32'h000000AB, 1'b0, 32'h000080FF, 8'h02, 8'h04, 8'h08, 32'h1122AB44);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd8,  32'h0, 1'b0, 32'h1122AB44, 8'h02, 8'h00, 8'h04, 32'h0);
      applyStimulus(1'b1, SZ_HALF, 1'b0, 32'd12, 32'hFFFF1234, 1'b0, 32'h1122AB44, 8'h02, 8'h04, 8'h08, 32'h12347F01);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd12, 32'h0, 1'b0, 32'h12347F01, 8'h02, 8'h00, 8'h04, 32'h0);

      // Errors: done+err in cycle 1, no strobes, RData unchanged
      applyStimulus(1'b0, SZ_WORD,    1'b0, 32'd6,  32'h0, 1'b1, 32'h12347F01, 8'h00, 8'h00, 8'h02, 32'h0);
      applyStimulus(1'b1, SZ_HALF,    1'b0, 32'd5,  32'h5555, 1'b1, 32'h12347F01, 8'h00, 8'h00, 8'h02, 32'h0);
      applyStimulus(1'b0, SZ_ILLEGAL, 1'b0, 32'd0,  32'h0, 1'b1, 32'h12347F01, 8'h00, 8'h00, 8'h02, 32'h0);
      applyStimulus(1'b1, SZ_WORD,    1'b0, 32'd60, 32'h01020304, 1'b1, 32'h12347F01, 8'h00, 8'h00, 8'h02, 32'h0);
      applyStimulus(1'b0, SZ_BYTE,    1'b0, 32'd61, 32'h0, 1'b1, 32'h12347F01, 8'h00, 8'h00, 8'h02, 32'h0);

      // Highest legal word: store then read back
      applyStimulus(1'b1, SZ_WORD, 1'b0, 32'd56, 32'hDEADBEEF, 1'b0, 32'h12347F01, 8'h00, 8'h02, 8'h04, 32'hDEADBEEF);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd56, 32'h0, 1'b0, 32'hDEADBEEF, 8'h02, 8'h00, 8'h04, 32'h0);
      checkOutput("memWord60Untouched", mem[15], 32'h0);

      // Reset during the read of a half store: nothing must be written
      @(negedge CLK);
      wr = 1'b1; size = SZ_HALF; sign_ext = 1'b0; Addr = 32'd8; WData = 32'h00005555; req = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      req = 1'b0;
      checkOutput("rdBeforeReset", {31'b0, ram_mRD}, 32'h1);
      Reset = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      checkResetOutputs();
      mwrSeen = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         mwrSeen[k] = ram_mWR;
      end
      checkOutput("noWriteAfterReset", {24'b0, mwrSeen}, 32'h0);
      checkOutput("word8Unchanged", mem[2], 32'h1122AB44);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0, 1'b0, 32'h1122AB44, 8'h02, 8'h00, 8'h04, 32'h0);

      // req held high for 10 edges: accepted only from IDLE, every third edge
      for (int n = 0; n < 4; n++) expQ.push_back('{expErr: 1'b0, expRdata: 32'hCAFE0123});
      mrdCount = 0;
      doneCount = 0;
      doneSeenBefore = 1'b0;
      @(negedge CLK);
      wr = 1'b0; size = SZ_WORD; sign_ext = 1'b0; Addr = 32'd0; WData = 32'h0; req = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge CLK);
         if (c == 10) req = 1'b0;
         if (ram_mRD) mrdCount++;
         if (done) begin
            doneCount++;
            if (doneSeenBefore)
               checkOutput("donePulseWidth", 32'h2, 32'h1);
         end
         if (ram_mRD && done)
            checkOutput("overlapRdDone", 32'h1, 32'h0);
         doneSeenBefore = done;
      end
      checkOutput("heldReqAccesses", mrdCount, 32'd4);
      checkOutput("heldReqDones", doneCount, 32'd4);
      checkOutput("idleAfterHeld", {31'b0, busy}, 32'h0);

      repeat (2) @(negedge CLK);
      checkOutput("scoreboardDrained", expQ.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
